solver_ram: RTL and testbench
=============================

# solver_ram

Four-port 64-bit word memory that answers the ODE solver's RAM bus: four independent address/data/direction port sets, each with a bidirectional data line. Each port reads combinationally and writes on the clock edge. The block resolves same-address write collisions, clears itself after reset, and records sticky error status. It sits between the solver datapath (Euler/interpolation/error blocks) and the stored matrices, vectors and results.

## Interface
- DATA_W, 64, word width
- ADDR_W, 11, address width
- DEPTH, 2048, number of words (≤ 2^ADDR_W)
- CLEAR_ON_RESET, 1, 1: zero-fill sweep after reset; 0: ready immediately

- Clk  in  1  clock; all state changes on rising edge
- Rst  in  1  asynchronous, active-low reset
- ADD1..ADD4  in  ADDR_W  port address
- read_write_en1..4  in  1  per-port direction; 1 = initiator writes, 0 = initiator reads
- Data1..Data4  inout  DATA_W  per-port data; driven by this block only when its read_write_en is 0
- ClrReq  in  1  synchronous request to re-run the zero-fill sweep
- Ready  out  1  memory is serviceable
- Collision  out  1  sticky: two or more ports wrote the same address in one cycle
- CollAddr  out  ADDR_W  address of the first collision since reset
- ParErr  out  1  sticky parity error (only with macro, see Configuration)
- ParAddr  out  ADDR_W  address of the first parity error

## Operation
- Two-state FSM: CLEAR and READY.
- Reset (Rst=0):
  - State goes to CLEAR if CLEAR_ON_RESET=1, else READY.
  - Sweep counter goes to 0.
  - Ready, Collision, CollAddr, ParErr and ParAddr all go to 0.
  - Array contents are not touched by reset itself.
- CLEAR:
  - Writes 0 to mem[cnt] each cycle and increments cnt.
  - Enters READY on the edge that writes DEPTH-1.
  - Port writes are ignored.
  - Each port with read_write_en=0 drives 0.
- READY:
  - Read: when read_write_en_x=0, Data_x = mem[ADDx] combinationally (zero-cycle latency from address).
  - Write: when read_write_en_x=1, the block tri-states Data_x and writes Data_x to mem[ADDx] on the rising edge.
  - An address ≥ DEPTH reads 0; a write to it is dropped.
- Same-cycle write collision on one address:
  - The lowest-numbered port wins.
  - Collision is set at that edge.
  - CollAddr is captured only if Collision was 0.
- Writes by different ports to different addresses all commit in the same cycle.
- Read and write of the same address in one cycle: the reader sees the old word; the new word is visible after the edge.
- ClrReq=1 in READY: next state is CLEAR, cnt=0, Ready drops on that edge. ClrReq is ignored while in CLEAR.
- Sticky flags clear only on reset.

## Timing
- Read latency 0 cycles: the initiator presents an address after edge k and samples Data at edge k+1.
- Write commits at the first rising edge where read_write_en=1.
- Ready rises DEPTH cycles after reset deassertion (CLEAR_ON_RESET=1), or at the first edge after deassertion (CLEAR_ON_RESET=0).
- Bus turnaround has no dead cycle: the drive enable is exactly ~read_write_en_x. Both ends decode the same signal, so there is no contention.
- Reset during CLEAR aborts the sweep and restarts it at 0 after deassertion.
- Reset mid-write: the write is lost and the array word is left unchanged.

## Configuration
- SOLVER_RAM_PARITY_EN defined:
  - Each word stores one extra even-parity bit, computed on every write (sweep zeros included).
  - On every READY cycle where port x reads an address < DEPTH whose stored parity mismatches, ParErr is set at the edge.
  - ParAddr is captured for the first error; among simultaneous errors the lowest port wins.
  - Read data is returned unmodified.
- Undefined: no parity storage; ParErr and ParAddr are tied to 0.

## Test plan
- CLEAR_ON_RESET=1, Rst low then high → Ready=0 for 2048 cycles, then 1; reading address 5 returns 0.
- Port 2 writes 64'h3FF0_0000_0000_0000 to address 12; next cycle port 4 reads 12 → Data4 = 64'h3FF0_0000_0000_0000, Data2 tri-stated only during the write cycle.
- Ports 1 and 3 write 64'hA and 64'hB to address 30 in the same cycle → mem[30]=64'hA, Collision=1, CollAddr=30. A later collision at 31 leaves CollAddr=30.
- Port 1 writes 64'h7 to address 40 while port 3 reads 40 in the same cycle → Data3 = old value (0) that cycle, 64'h7 the next cycle.
- ClrReq pulse in READY after writes to address 100 → Ready=0 for 2048 cycles, then address 100 reads 0. Pulling Rst low mid-sweep restarts the 2048-cycle count.
- With SOLVER_RAM_PARITY_EN, force the parity bit of address 7 inverted, then read via port 2 → ParErr=1 and ParAddr=7 at the next edge, Data2 unmodified.

Source files
------------

// File: rtl/solver_ram_if.sv
// solver_ram_if: address, direction, clear-request and status signals of the
// four-port solver RAM. The bidirectional data lines stay as plain inout
// ports on solver_ram so their tri-state resolution sits on ordinary nets.
interface solver_ram_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] ADD1;
  logic [ADDR_W-1:0] ADD2;
  logic [ADDR_W-1:0] ADD3;
  logic [ADDR_W-1:0] ADD4;
  logic              read_write_en1;
  logic              read_write_en2;
  logic              read_write_en3;
  logic              read_write_en4;
  logic              ClrReq;
  logic              Ready;
  logic              Collision;
  logic [ADDR_W-1:0] CollAddr;
  logic              ParErr;
  logic [ADDR_W-1:0] ParAddr;

  modport master (
    output ADD1, ADD2, ADD3, ADD4,
    output read_write_en1, read_write_en2, read_write_en3, read_write_en4,
    output ClrReq,
    input  Ready, Collision, CollAddr, ParErr, ParAddr
  );

  modport slave (
    input  ADD1, ADD2, ADD3, ADD4,
    input  read_write_en1, read_write_en2, read_write_en3, read_write_en4,
    input  ClrReq,
    output Ready, Collision, CollAddr, ParErr, ParAddr
  );
endinterface

// File: rtl/solver_ram.sv
// solver_ram: four-port DATA_W-bit word memory for the ODE solver.
// Combinational reads, writes on the rising edge, lowest port wins a
// same-address write collision, zero-fill sweep after reset / ClrReq,
// sticky collision status.
// Optional feature macro: SOLVER_RAM_PARITY_EN adds a stored even-parity
// bit per word and sticky parity-error status (ParErr/ParAddr).
module solver_ram #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 11,
  parameter int DEPTH          = 2048,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  solver_ram_if.slave       bus,
  inout  wire  [DATA_W-1:0] Data1,
  inout  wire  [DATA_W-1:0] Data2,
  inout  wire  [DATA_W-1:0] Data3,
  inout  wire  [DATA_W-1:0] Data4
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] cnt_r, cnt_next_s;
  logic              ready_r;
  logic              coll_r;
  logic [ADDR_W-1:0] coll_addr_r;
  logic              coll_hit_s;
  logic [ADDR_W-1:0] coll_addr_s;
  logic [ADDR_W-1:0] addr_s  [4];
  logic              wr_s    [4];
  logic [DATA_W-1:0] wdata_s [4];
  logic [DATA_W-1:0] rdata_s [4];
  logic [DATA_W-1:0] mem     [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  // Gather per-port address and direction into arrays.
  always_comb begin
    addr_s[0] = bus.ADD1;
    addr_s[1] = bus.ADD2;
    addr_s[2] = bus.ADD3;
    addr_s[3] = bus.ADD4;
    wr_s[0]   = bus.read_write_en1;
    wr_s[1]   = bus.read_write_en2;
    wr_s[2]   = bus.read_write_en3;
    wr_s[3]   = bus.read_write_en4;
  end

  // Capture write data from the shared lines (kept apart from the read path).
  always_comb begin
    wdata_s[0] = Data1;
    wdata_s[1] = Data2;
    wdata_s[2] = Data3;
    wdata_s[3] = Data4;
  end

  // Combinational read: zero while sweeping or for out-of-range addresses.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata_s[i] = '0;
      if (state_r == READY && in_range(addr_s[i])) begin
        rdata_s[i] = mem[addr_s[i]];
      end else begin
        rdata_s[i] = '0;
      end
    end
  end

  // Drive enable is exactly the inverse of the port direction.
  assign Data1 = bus.read_write_en1 ? {DATA_W{1'bz}} : rdata_s[0];
  assign Data2 = bus.read_write_en2 ? {DATA_W{1'bz}} : rdata_s[1];
  assign Data3 = bus.read_write_en3 ? {DATA_W{1'bz}} : rdata_s[2];
  assign Data4 = bus.read_write_en4 ? {DATA_W{1'bz}} : rdata_s[3];

  // Detect same-address writes; scanning downward leaves the lowest pair's address.
  always_comb begin
    coll_hit_s  = 1'b0;
    coll_addr_s = '0;
    for (int i = 2; i >= 0; i--) begin
      for (int j = 3; j > i; j--) begin
        logic hit;
        hit = wr_s[i] && wr_s[j] && (addr_s[i] == addr_s[j]) && in_range(addr_s[i]);
        coll_hit_s  = coll_hit_s | hit;
        coll_addr_s = hit ? addr_s[i] : coll_addr_s;
      end
    end
  end

  // Next-state logic for the CLEAR sweep / READY service FSM.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      CLEAR: begin
        if (cnt_r == LAST_L) begin
          state_next_s = READY;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s   = cnt_r + ADDR_W'(1);
        end
      end
      READY: begin
        if (bus.ClrReq) begin
          state_next_s = CLEAR;
          cnt_next_s   = '0;
        end else begin
          state_next_s = READY;
        end
      end
      default: begin
        state_next_s = CLEAR;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State, sweep counter, Ready and sticky collision registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_r       <= '0;
      ready_r     <= 1'b0;
      coll_r      <= 1'b0;
      coll_addr_r <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= (state_next_s == READY);
      if (state_r == READY && coll_hit_s) begin
        coll_r <= 1'b1;
        if (!coll_r) begin
          coll_addr_r <= coll_addr_s;
        end
      end
    end
  end

  // Array update: sweep zeros, or port writes with the lowest port applied last.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      // Contents are retained through reset; only an in-flight write is lost.
    end else if (state_r == CLEAR) begin
      mem[cnt_r] <= '0;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (wr_s[i] && in_range(addr_s[i])) begin
          mem[addr_s[i]] <= wdata_s[i];
        end
      end
    end
  end

  assign bus.Ready     = ready_r;
  assign bus.Collision = coll_r;
  assign bus.CollAddr  = coll_addr_r;

`ifdef SOLVER_RAM_PARITY_EN
  logic              par_mem [DEPTH];
  logic              par_err_r;
  logic [ADDR_W-1:0] par_addr_r;
  logic              perr_hit_s;
  logic [ADDR_W-1:0] perr_addr_s;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Parity array update, mirroring the data array write order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      // Stored parity is retained through reset like the data it covers.
    end else if (state_r == CLEAR) begin
      par_mem[cnt_r] <= even_parity('0);
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (wr_s[i] && in_range(addr_s[i])) begin
          par_mem[addr_s[i]] <= even_parity(wdata_s[i]);
        end
      end
    end
  end

  // Parity check on every reading port; downward scan lets the lowest port win.
  always_comb begin
    perr_hit_s  = 1'b0;
    perr_addr_s = '0;
    for (int i = 3; i >= 0; i--) begin
      logic bad;
      bad = (state_r == READY) && !wr_s[i] && in_range(addr_s[i]) &&
            (even_parity(mem[addr_s[i]]) != par_mem[addr_s[i]]);
      perr_hit_s  = perr_hit_s | bad;
      perr_addr_s = bad ? addr_s[i] : perr_addr_s;
    end
  end

  // Sticky parity error flag and first-error address.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      par_err_r  <= 1'b0;
      par_addr_r <= '0;
    end else if (perr_hit_s) begin
      par_err_r <= 1'b1;
      if (!par_err_r) begin
        par_addr_r <= perr_addr_s;
      end
    end
  end

  assign bus.ParErr  = par_err_r;
  assign bus.ParAddr = par_addr_r;
`else
  assign bus.ParErr  = 1'b0;
  assign bus.ParAddr = '0;
`endif

endmodule

// File: tb/tb_solver_ram.sv
// tb_solver_ram: directed stimulus with a queue-based scoreboard; a monitor
// on the falling edge pops expected values and compares them with the DUT.
module tb_solver_ram;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  localparam int K_DATA  = 0;
  localparam int K_READY = 1;
  localparam int K_COLL  = 2;
  localparam int K_CADDR = 3;
  localparam int K_PERR  = 4;
  localparam int K_PADDR = 5;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic [DATA_W-1:0] drv [4];

  solver_ram_if #(.ADDR_W(ADDR_W)) bus ();
  wire [DATA_W-1:0] Data1, Data2, Data3, Data4;

  assign Data1 = bus.read_write_en1 ? drv[0] : {DATA_W{1'bz}};
  assign Data2 = bus.read_write_en2 ? drv[1] : {DATA_W{1'bz}};
  assign Data3 = bus.read_write_en3 ? drv[2] : {DATA_W{1'bz}};
  assign Data4 = bus.read_write_en4 ? drv[3] : {DATA_W{1'bz}};

  solver_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus),
    .Data1(Data1), .Data2(Data2), .Data3(Data3), .Data4(Data4)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          kind;
    int          port;
    logic [63:0] want;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  function automatic logic [63:0] observe(input int kind, input int port);
    case (kind)
      K_DATA: begin
        case (port)
          1:       return Data1;
          2:       return Data2;
          3:       return Data3;
          default: return Data4;
        endcase
      end
      K_READY: return {63'd0, bus.Ready};
      K_COLL:  return {63'd0, bus.Collision};
      K_CADDR: return {53'd0, bus.CollAddr};
      K_PERR:  return {63'd0, bus.ParErr};
      default: return {53'd0, bus.ParAddr};
    endcase
  endfunction

  task automatic expect_val(input int kind, input int port, input logic [63:0] want, input string name);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.want = want;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    forever begin
      @(negedge Clk);
      while (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check(mon_e.name, observe(mon_e.kind, mon_e.port), mon_e.want);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic rw, input logic [ADDR_W-1:0] a,
                          input logic [63:0] d);
    drv[p-1] = d;
    case (p)
      1: begin bus.ADD1 = a; bus.read_write_en1 = rw; end
      2: begin bus.ADD2 = a; bus.read_write_en2 = rw; end
      3: begin bus.ADD3 = a; bus.read_write_en3 = rw; end
      default: begin bus.ADD4 = a; bus.read_write_en4 = rw; end
    endcase
  endtask

  task automatic all_read(input logic [ADDR_W-1:0] a);
    for (int p = 1; p <= 4; p++) set_port(p, 1'b0, a, 64'd0);
  endtask

  // Count rising edges until Ready, bounded so a stuck sweep still ends.
  task automatic wait_ready(input string name, input int want_n);
    int n;
    n = 0;
    while (n < 4000) begin
      step();
      n++;
      if (bus.Ready) break;
    end
    check(name, 64'(n), 64'(want_n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ClrReq = 1'b0;
    all_read(11'd0);
    Rst = 1'b0;
    step();
    step();
    expect_val(K_READY, 0, 64'd0, "reset_ready");
    expect_val(K_COLL,  0, 64'd0, "reset_coll");
    expect_val(K_CADDR, 0, 64'd0, "reset_colladdr");
    expect_val(K_PERR,  0, 64'd0, "reset_parerr");
    expect_val(K_PADDR, 0, 64'd0, "reset_paraddr");
    step();

    // Initial sweep: Ready after exactly DEPTH edges.
    Rst = 1'b1;
    wait_ready("sweep_len_after_reset", DEPTH);
    set_port(1, 1'b0, 11'd5, 64'd0);
    expect_val(K_DATA, 1, 64'd0, "read_addr5_zero");
    step();

    // Port 2 writes addr 12; port 4 reads it in the same and the next cycle.
    set_port(2, 1'b1, 11'd12, 64'h3FF0_0000_0000_0000);
    set_port(4, 1'b0, 11'd12, 64'd0);
    expect_val(K_DATA, 2, 64'h3FF0_0000_0000_0000, "data2_during_write");
    expect_val(K_DATA, 4, 64'd0, "data4_old_during_write");
    step();
    set_port(2, 1'b0, 11'd12, 64'd0);
    expect_val(K_DATA, 4, 64'h3FF0_0000_0000_0000, "data4_read12");
    expect_val(K_DATA, 2, 64'h3FF0_0000_0000_0000, "data2_read12");
    expect_val(K_COLL, 0, 64'd0, "no_collision_yet");
    step();

    // Collision at 30: port 1 wins.
    all_read(11'd0);
    set_port(1, 1'b1, 11'd30, 64'hA);
    set_port(3, 1'b1, 11'd30, 64'hB);
    step();
    all_read(11'd30);
    expect_val(K_DATA,  1, 64'hA, "coll30_winner_p1");
    expect_val(K_DATA,  3, 64'hA, "coll30_winner_p3view");
    expect_val(K_COLL,  0, 64'd1, "coll30_flag");
    expect_val(K_CADDR, 0, 64'd30, "coll30_addr");
    step();

    // Second collision at 31 (ports 2,4): port 2 wins, CollAddr stays 30.
    set_port(2, 1'b1, 11'd31, 64'hC);
    set_port(4, 1'b1, 11'd31, 64'hD);
    step();
    all_read(11'd31);
    expect_val(K_DATA,  4, 64'hC, "coll31_winner_p2");
    expect_val(K_CADDR, 0, 64'd30, "colladdr_first_kept");
    expect_val(K_COLL,  0, 64'd1, "coll_sticky");
    step();

    // Read during write of the same address.
    all_read(11'd0);
    set_port(1, 1'b1, 11'd40, 64'h7);
    set_port(3, 1'b0, 11'd40, 64'd0);
    expect_val(K_DATA, 3, 64'd0, "raw_old_value");
    step();
    set_port(1, 1'b0, 11'd40, 64'd0);
    expect_val(K_DATA, 3, 64'h7, "raw_new_value");
    step();

    // Four writes to distinct addresses commit together.
    for (int p = 1; p <= 4; p++) set_port(p, 1'b1, 11'(49 + p), 64'h1111_1111_1111_1111 * p);
    step();
    for (int p = 1; p <= 4; p++) set_port(p, 1'b0, 11'(49 + p), 64'd0);
    expect_val(K_DATA, 1, 64'h1111_1111_1111_1111, "multi_wr_p1");
    expect_val(K_DATA, 2, 64'h2222_2222_2222_2222, "multi_wr_p2");
    expect_val(K_DATA, 3, 64'h3333_3333_3333_3333, "multi_wr_p3");
    expect_val(K_DATA, 4, 64'h4444_4444_4444_4444, "multi_wr_p4");
    step();

    // ClrReq sweep wipes address 100.
    set_port(1, 1'b1, 11'd100, 64'hDEAD_BEEF_0000_0100);
    step();
    set_port(1, 1'b0, 11'd100, 64'd0);
    expect_val(K_DATA, 1, 64'hDEAD_BEEF_0000_0100, "addr100_written");
    bus.ClrReq = 1'b1;
    step();
    bus.ClrReq = 1'b0;
    expect_val(K_READY, 0, 64'd0, "clrreq_ready_drop");
    expect_val(K_DATA,  1, 64'd0, "clear_reads_zero");
    wait_ready("sweep_len_after_clrreq", DEPTH);
    expect_val(K_DATA, 1, 64'd0, "addr100_cleared");
    set_port(2, 1'b0, 11'd12, 64'd0);
    expect_val(K_DATA, 2, 64'd0, "addr12_cleared");
    step();

    // Reset mid-sweep restarts the count and clears sticky status.
    bus.ClrReq = 1'b1;
    step();
    bus.ClrReq = 1'b0;
    repeat (1000) step();
    Rst = 1'b0;
    expect_val(K_READY, 0, 64'd0, "midsweep_reset_ready");
    expect_val(K_COLL,  0, 64'd0, "reset_clears_coll");
    expect_val(K_CADDR, 0, 64'd0, "reset_clears_colladdr");
    step();
    Rst = 1'b1;
    wait_ready("sweep_len_after_midsweep_reset", DEPTH);
    set_port(3, 1'b0, 11'd30, 64'd0);
    expect_val(K_DATA, 3, 64'd0, "addr30_cleared");
    step();

`ifdef SOLVER_RAM_PARITY_EN
    // Corrupt stored parity of address 7 and read it through port 2.
    set_port(1, 1'b1, 11'd7, 64'h5);
    step();
    set_port(1, 1'b0, 11'd0, 64'd0);
    dut.par_mem[7] = ~dut.par_mem[7];
    set_port(2, 1'b0, 11'd7, 64'd0);
    expect_val(K_DATA, 2, 64'h5, "parity_data_unmodified");
    expect_val(K_PERR, 0, 64'd0, "parity_not_yet");
    step();
    expect_val(K_PERR,  0, 64'd1, "parity_err_flag");
    expect_val(K_PADDR, 0, 64'd7, "parity_err_addr");
    step();
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
